// File: rtl/ib_ram_page_writer.sv
`default_nettype none
// ============================================================================
// Module   : ib_ram_page_writer
// Brief    : Streams one LUT image into the IB-VNU symmetric LUT RAMs with a
//            strictly sequential page address over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module ib_ram_page_writer #(
  parameter int ENTRY_ADDR    = 7,
  parameter int BANK_NUM      = 2,
  parameter int LUT_PORT_SIZE = 4,
  parameter int ITER_W        = 5
) (
  input  logic                              write_clk,
  input  logic                              rstn,
  input  logic                              load_start,
  input  logic [ITER_W-1:0]                 load_iter,
  input  logic                              load_abort,
  input  logic [LUT_PORT_SIZE*BANK_NUM-1:0] lut_in_data,
  input  logic                              lut_in_valid,
  output logic                              lut_in_ready,
  output logic [ENTRY_ADDR-1:0]             page_addr_ram,
  output logic [LUT_PORT_SIZE*BANK_NUM-1:0] ram_write_data_1,
  output logic                              ib_ram_we,
  output logic                              busy,
  output logic [ITER_W-1:0]                 cur_iter,
  output logic                              load_done,
  output logic                              load_aborted,
  output logic                              start_err
);

  localparam logic [ENTRY_ADDR:0] c_DEPTH = {1'b1, {ENTRY_ADDR{1'b0}}};
  localparam logic [ENTRY_ADDR:0] c_LAST  = {1'b0, {ENTRY_ADDR{1'b1}}};
  localparam logic [ENTRY_ADDR:0] c_ONE   = {{ENTRY_ADDR{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_FLUSH = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ENTRY_ADDR:0]   r_cnt;
  logic [ENTRY_ADDR:0]   w_cnt_nxt;
  logic [ITER_W-1:0]     r_pend_iter;
  logic                  w_wr;
  logic                  w_abort;

  // Abort outranks a same-cycle handshake, so the in-flight entry is dropped.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_wr        = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (load_start) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_LOAD: begin
        if (load_abort) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else if (lut_in_valid && lut_in_ready) begin
          w_wr      = 1'b1;
          w_cnt_nxt = r_cnt + c_ONE;
          if (r_cnt == c_LAST) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        if (load_abort) begin
          w_state_nxt = S_IDLE;
          w_abort     = 1'b1;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pend_iter <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if ((r_state == S_IDLE) && load_start) begin
        r_pend_iter <= load_iter;
      end
    end
  end

  // Ready is registered from the next state/count so it never sees lut_in_valid.
  always_ff @(posedge write_clk) begin
    if (!rstn) begin
      lut_in_ready     <= 1'b0;
      page_addr_ram    <= '0;
      ram_write_data_1 <= '0;
      ib_ram_we        <= 1'b0;
      cur_iter         <= '0;
      load_done        <= 1'b0;
      load_aborted     <= 1'b0;
      start_err        <= 1'b0;
    end else begin
      lut_in_ready <= (w_state_nxt == S_LOAD) && (w_cnt_nxt < c_DEPTH);
      ib_ram_we    <= w_wr;
      if (w_wr) begin
        page_addr_ram    <= r_cnt[ENTRY_ADDR-1:0];
        ram_write_data_1 <= lut_in_data;
      end
      load_done    <= (r_state == S_DONE);
      load_aborted <= w_abort;
      if (r_state == S_DONE) begin
        cur_iter <= r_pend_iter;
      end
      if (load_start && (r_state != S_IDLE)) begin
        start_err <= 1'b1;
      end
    end
  end

  assign busy = (r_state == S_LOAD) || (r_state == S_FLUSH);

endmodule
`default_nettype wire

// File: tb/tb_ib_ram_page_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ib_ram_page_writer
// Brief    : Scoreboard bench for ib_ram_page_writer using directed loads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ib_ram_page_writer;

  logic       write_clk;
  logic       rstn;
  logic       load_start;
  logic [4:0] load_iter;
  logic       load_abort;
  logic [7:0] lut_in_data;
  logic       lut_in_valid;
  logic       lut_in_ready;
  logic [6:0] page_addr_ram;
  logic [7:0] ram_write_data_1;
  logic       ib_ram_we;
  logic       busy;
  logic [4:0] cur_iter;
  logic       load_done;
  logic       load_aborted;
  logic       start_err;

  ib_ram_page_writer dut (
    .write_clk        (write_clk),
    .rstn             (rstn),
    .load_start       (load_start),
    .load_iter        (load_iter),
    .load_abort       (load_abort),
    .lut_in_data      (lut_in_data),
    .lut_in_valid     (lut_in_valid),
    .lut_in_ready     (lut_in_ready),
    .page_addr_ram    (page_addr_ram),
    .ram_write_data_1 (ram_write_data_1),
    .ib_ram_we        (ib_ram_we),
    .busy             (busy),
    .cur_iter         (cur_iter),
    .load_done        (load_done),
    .load_aborted     (load_aborted),
    .start_err        (start_err)
  );

  typedef struct { logic [6:0] addr; logic [7:0] data; int cyc; } wr_t;
  typedef struct { logic [4:0] iter; int cyc; } dn_t;

  wr_t  wq[$];
  dn_t  dq[$];
  int   aq[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  logic [4:0] exp_cur = '0;
  wr_t  mon_w;
  dn_t  mon_d;
  int   mon_a;

  initial begin
    write_clk = 1'b0;
    forever #5 write_clk = ~write_clk;
  end

  always @(posedge write_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: every write/done/abort pulse must match the head of its queue in content and cycle.
  always @(negedge write_clk) begin
    if (ib_ram_we === 1'b1 || (wq.size() > 0 && wq[0].cyc == cyc)) begin
      if (wq.size() == 0) begin
        check("unexpected_we", ib_ram_we, 0);
      end else begin
        mon_w = wq.pop_front();
        check("we", ib_ram_we, 1);
        check("we_cycle", cyc, mon_w.cyc);
        check("addr", page_addr_ram, mon_w.addr);
        check("data", ram_write_data_1, mon_w.data);
      end
    end
    if (load_done === 1'b1 || (dq.size() > 0 && dq[0].cyc == cyc)) begin
      if (dq.size() == 0) begin
        check("unexpected_done", load_done, 0);
      end else begin
        mon_d = dq.pop_front();
        check("done", load_done, 1);
        check("done_cycle", cyc, mon_d.cyc);
        check("done_iter", cur_iter, mon_d.iter);
      end
    end
    if (load_aborted === 1'b1 || (aq.size() > 0 && aq[0] == cyc)) begin
      if (aq.size() == 0) begin
        check("unexpected_abort", load_aborted, 0);
      end else begin
        mon_a = aq.pop_front();
        check("aborted", load_aborted, 1);
        check("abort_cycle", cyc, mon_a);
      end
    end
  end

  task automatic tick();
    @(posedge write_clk);
    #1;
  endtask

  task automatic check_reset_vals();
    check("rst_addr", page_addr_ram, 0);
    check("rst_data", ram_write_data_1, 0);
    check("rst_we", ib_ram_we, 0);
    check("rst_ready", lut_in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_cur_iter", cur_iter, 0);
    check("rst_done", load_done, 0);
    check("rst_aborted", load_aborted, 0);
    check("rst_start_err", start_err, 0);
  endtask

  // kind: 0 normal, 1 abort at entry stop_at, 2 reset at stop_at,
  //       3 extra load_start at stop_at, 4 start together with abort in IDLE
  task automatic do_load(input logic [4:0] iter, input bit toggle, input int stop_at,
                         input int kind, input logic [7:0] dmask);
    int last_hs;
    load_start   = 1'b1;
    load_iter    = iter;
    load_abort   = (kind == 4);
    lut_in_valid = toggle;
    lut_in_data  = 8'hFF;
    tick();
    load_start   = 1'b0;
    load_abort   = 1'b0;
    lut_in_valid = 1'b0;
    if (kind == 4) begin
      check("sa_busy", busy, 1);
      check("sa_ready", lut_in_ready, 1);
    end
    if (toggle) tick();
    last_hs = 0;
    for (int i = 0; i < 128; i++) begin
      lut_in_valid = 1'b1;
      lut_in_data  = 8'(i) ^ dmask;
      if (i == stop_at && kind == 1) begin
        load_abort = 1'b1;
        aq.push_back(cyc + 1);
        tick();
        load_abort   = 1'b0;
        lut_in_valid = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_ready", lut_in_ready, 0);
        check("abort_cur_iter", cur_iter, exp_cur);
        repeat (3) tick();
        return;
      end
      if (i == stop_at && kind == 2) begin
        rstn = 1'b0;
        tick();
        lut_in_valid = 1'b0;
        exp_cur = '0;
        check_reset_vals();
        rstn = 1'b1;
        repeat (2) tick();
        return;
      end
      load_start = (kind == 3 && i == stop_at);
      if (kind == 3 && i == stop_at) load_iter = 5'd20;
      wq.push_back('{addr: 7'(i), data: lut_in_data, cyc: cyc + 1});
      last_hs = cyc + 1;
      tick();
      load_start = 1'b0;
      if (toggle) begin
        lut_in_valid = 1'b0;
        tick();
      end
    end
    lut_in_valid = 1'b0;
    dq.push_back('{iter: iter, cyc: last_hs + 2});
    exp_cur = iter;
    repeat (4) tick();
    check("post_busy", busy, 0);
    check("post_cur_iter", cur_iter, exp_cur);
  endtask

  initial begin
    rstn         = 1'b0;
    load_start   = 1'b0;
    load_iter    = '0;
    load_abort   = 1'b0;
    lut_in_data  = '0;
    lut_in_valid = 1'b0;
    repeat (3) tick();
    check_reset_vals();
    rstn = 1'b1;
    tick();

    do_load(5'd3, 1'b0, -1, 0, 8'h00);   // back-to-back, data = index
    do_load(5'd6, 1'b1, -1, 0, 8'hA5);   // valid toggling every cycle
    do_load(5'd9, 1'b0, 40, 1, 8'h00);   // abort with entry 40 handshake
    do_load(5'd12, 1'b0, 10, 3, 8'h3C);  // load_start while busy
    check("start_err_set", start_err, 1);
    repeat (5) tick();
    check("start_err_sticky", start_err, 1);
    do_load(5'd17, 1'b0, 70, 2, 8'h00);  // reset at entry 70
    do_load(5'd2, 1'b0, -1, 0, 8'hFF);   // full load restarts at address 0
    do_load(5'd5, 1'b0, -1, 4, 8'h5A);   // start + abort together in IDLE
    check("start_err_clear", start_err, 0);

    repeat (5) tick();
    check("wq_empty", wq.size(), 0);
    check("dq_empty", dq.size(), 0);
    check("aq_empty", aq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
